line_rasterizer: RTL
====================

// Module: line_rasterizer
// PURPOSE
//  Qsys Avalon-MM master component, upstream of the SDRAM framebuffer that the VGA pixel DMA scans out.
//  Accepts one line command (two signed endpoints, RGB565 colour) and draws it with integer Bresenham.
//  Emits one 16-bit pixel write per pixel into SDRAM. Pixels off-screen are clipped, not written.
// PARAMETERS
//  COORD_W    11            signed endpoint width (two's complement)
//  FB_WIDTH   320           framebuffer width in pixels
//  FB_HEIGHT  240           framebuffer height in pixels
//  FB_BASE    32'h0000_0000 byte address of pixel (0,0) in SDRAM
//  ADDR_W     32            Avalon byte-address width
// PORTS
//  clk              in   1        component clock; all logic on rising edge
//  reset            in   1        synchronous, active-high
//  cmd_valid        in   1        command present
//  cmd_ready        out  1        high only in IDLE; accept = valid & ready
//  cmd_x0,cmd_y0    in   COORD_W  start point (signed)
//  cmd_x1,cmd_y1    in   COORD_W  end point (signed, inclusive)
//  cmd_color        in   16       RGB565 pixel value
//  busy             out  1        high from accept until done
//  done             out  1        one-cycle pulse after last pixel handled
//  avm_address      out  ADDR_W   FB_BASE + (y*FB_WIDTH + x)*2
//  avm_write        out  1        write request
//  avm_writedata    out  16       = latched cmd_color
//  avm_byteenable   out  2        constant 2'b11 while avm_write
//  avm_waitrequest  in   1        slave stall
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1, busy=0, done=0, avm_write=0, avm_address=0, avm_writedata=0.
//  FSM: IDLE -accept-> SETUP (latch endpoints/colour; dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+-1, err=dx+dy)
//   -> DRAW (one pixel per step) -> DONE (done=1 one cycle) -> IDLE.
//  DRAW step at (x,y): if 0<=x<FB_WIDTH and 0<=y<FB_HEIGHT, register avm_write=1 with address/data.
//   Otherwise no write; step in one cycle.
//  Avalon rule: address/data/write held stable while avm_write & avm_waitrequest.
//   Next pixel is loaded on the same edge the write is accepted (write & !waitrequest).
//   Peak throughput is 1 pixel/clk.
//  Step: e2=2*err; if e2>=dy {err+=dy; x+=sx}; if e2<=dx {err+=dx; y+=sy}; both may apply.
//   Exit DRAW after plotting (x1,y1).
//  err/e2 carry COORD_W+2 bits signed; no overflow for any legal COORD_W input.
//  Equal endpoints: exactly one pixel (or none if clipped); done still pulses.
//  Fully off-screen line: zero writes; stepping still runs; done pulses.
//  Latency: accept -> first avm_write = 2 clk (SETUP, then DRAW register), absent clipping.
//  done asserts the clk after final write is accepted; cmd_ready returns the following clk.
//  cmd_valid while busy is ignored (ready=0); no queuing.
//  reset mid-line: next edge forces IDLE and drops avm_write. In-flight pixel may or may not land.
//   The slave shares this reset.
// STRUCTURE
//  flightgpa_gfx_defs.vh: FB_WIDTH/FB_HEIGHT/FB_BASE defaults, RGB565 field macros, state encodings.
//  Sub-module fb_addr_gen: comb (x,y) -> byte address.
//   Constant-multiply y*FB_WIDTH as shifts/adds; shared with future fill/blit blocks.
// TESTING (FB_BASE=0, waitrequest=0 unless stated)
//  (0,0)-(3,0), colour 16'hF800 -> writes @0x0,0x2,0x4,0x6, data F800, BE=11, then one done pulse.
//  (3,0)-(0,0) -> same pixels in order @0x6,0x4,0x2,0x0.
//  (5,5)-(5,5) -> single write @0xC8A; done 1 clk later.
//  (0,0)-(2,4) -> pixels (0,0),(1,1),(1,2),(2,3),(2,4), addrs 0x0,0x282,0x502,0x784,0xA04.
//   Rerun with waitrequest high 3 clk on each write -> address/data stable while stalled, same sequence.
//  (-2,0)-(1,0) -> only @0x0,0x2 written; (400,300)-(410,300) -> zero writes, done pulses.
//  reset asserted 2 clk into a 10-pixel line -> avm_write=0 and cmd_ready=1 after edge; new command runs clean.

Source files
------------

// File: rtl/line_rasterizer_pkg.sv
// Shared definitions for the line rasterizer: default geometry, FSM state
// encoding and an RGB565 packing helper.
package line_rasterizer_pkg;

  localparam int          DEF_COORD_W   = 11;
  localparam int          DEF_FB_WIDTH  = 320;
  localparam int          DEF_FB_HEIGHT = 240;
  localparam int          DEF_ADDR_W    = 32;
  localparam logic [31:0] DEF_FB_BASE   = 32'h0000_0000;
  localparam logic [1:0]  BE_ALL        = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } line_state_t;

  function automatic logic [15:0] rgb565(input logic [4:0] r, input logic [5:0] g,
                                         input logic [4:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/line_rasterizer_if.sv
// Avalon-MM write-only master bus from the rasterizer to the SDRAM framebuffer.
// A write transfers on a rising edge where avm_write=1 and avm_waitrequest=0;
// while avm_write=1 and avm_waitrequest=1 the master holds address/data/write.
interface line_rasterizer_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [15:0]       avm_writedata;
  logic [1:0]        avm_byteenable;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_write, avm_writedata, avm_byteenable,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_write, avm_writedata, avm_byteenable,
    output avm_waitrequest
  );
endinterface

// File: rtl/line_rasterizer_fb_addr_gen.sv
// Combinational (x,y) -> framebuffer byte address for 16-bit pixels.
// The row multiply is a constant shift/add tree so no multiplier is needed.
module line_rasterizer_fb_addr_gen #(
  parameter int                COORD_W  = 11,
  parameter int                FB_WIDTH = 320,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] FB_BASE  = '0
) (
  input  logic [COORD_W-2:0] px,
  input  logic [COORD_W-2:0] py,
  output logic [ADDR_W-1:0]  addr
);

  logic [ADDR_W-1:0] row;

  always_comb begin
    row = '0;
    for (int i = 0; i < 32; i++) begin
      if (FB_WIDTH[i]) row = row + (ADDR_W'(py) << i);
    end
    addr = FB_BASE + ((row + ADDR_W'(px)) << 1);
  end

endmodule

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: accepts one line command, issues one clipped
// 16-bit Avalon-MM write per on-screen pixel, then pulses done.
module line_rasterizer
  import line_rasterizer_pkg::*;
#(
  parameter int                COORD_W   = DEF_COORD_W,
  parameter int                FB_WIDTH  = DEF_FB_WIDTH,
  parameter int                FB_HEIGHT = DEF_FB_HEIGHT,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] FB_BASE   = ADDR_W'(DEF_FB_BASE)
) (
  input  logic                      clk,
  input  logic                      reset,
  // Command handshake: accepted on a rising edge with cmd_valid & cmd_ready.
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic signed [COORD_W-1:0] cmd_x0,
  input  logic signed [COORD_W-1:0] cmd_y0,
  input  logic signed [COORD_W-1:0] cmd_x1,
  input  logic signed [COORD_W-1:0] cmd_y1,
  input  logic [15:0]               cmd_color,
  output logic                      busy,
  output logic                      done,
  output line_state_t               state_dbg,
  line_rasterizer_if.master         avm
);

  localparam int ERR_W = COORD_W + 2;
  localparam logic signed [COORD_W-1:0] ONE   = COORD_W'(1);
  localparam logic signed [COORD_W-1:0] X_LIM = COORD_W'(FB_WIDTH);
  localparam logic signed [COORD_W-1:0] Y_LIM = COORD_W'(FB_HEIGHT);

  line_state_t state, state_nxt;

  logic signed [COORD_W-1:0] x, y, x_end, y_end, x_nxt, y_nxt;
  logic signed [ERR_W-1:0]   dx, dy, err, err_nxt, e2;
  logic signed [ERR_W-1:0]   diff_x, diff_y, abs_x, abs_y;
  logic                      step_left, step_up;
  logic [15:0]               color;
  logic                      last_q, on_screen, at_end, advance;
  logic [ADDR_W-1:0]         pix_addr, addr_q;
  logic                      write_q;
  logic [15:0]               data_q;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // A stalled write blocks the pixel pipeline; otherwise one step per clock.
  assign advance = !(write_q && avm.avm_waitrequest);

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    state_dbg = state;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = ST_SETUP;
      end
      ST_SETUP: state_nxt = ST_DRAW;
      ST_DRAW:  if (advance && last_q) state_nxt = ST_DONE;
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    diff_x  = ERR_W'(x_end) - ERR_W'(x);
    diff_y  = ERR_W'(y_end) - ERR_W'(y);
    abs_x   = diff_x[ERR_W-1] ? -diff_x : diff_x;
    abs_y   = diff_y[ERR_W-1] ? -diff_y : diff_y;
    e2      = err <<< 1;
    err_nxt = err;
    x_nxt   = x;
    y_nxt   = y;
    if (e2 >= dy) begin
      err_nxt = err_nxt + dy;
      x_nxt   = step_left ? x - ONE : x + ONE;
    end
    if (e2 <= dx) begin
      err_nxt = err_nxt + dx;
      y_nxt   = step_up ? y - ONE : y + ONE;
    end
    on_screen = !x[COORD_W-1] && (x < X_LIM) && !y[COORD_W-1] && (y < Y_LIM);
    at_end    = (x == x_end) && (y == y_end);
  end

  line_rasterizer_fb_addr_gen #(
    .COORD_W  (COORD_W),
    .FB_WIDTH (FB_WIDTH),
    .ADDR_W   (ADDR_W),
    .FB_BASE  (FB_BASE)
  ) u_addr_gen (
    .px   (x[COORD_W-2:0]),
    .py   (y[COORD_W-2:0]),
    .addr (pix_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            x     <= cmd_x0;
            y     <= cmd_y0;
            x_end <= cmd_x1;
            y_end <= cmd_y1;
            color <= cmd_color;
          end
        end
        ST_SETUP: begin
          dx        <= abs_x;
          dy        <= -abs_y;
          err       <= abs_x - abs_y;
          step_left <= diff_x[ERR_W-1];
          step_up   <= diff_y[ERR_W-1];
          last_q    <= 1'b0;
        end
        ST_DRAW: begin
          if (advance) begin
            if (last_q) begin
              write_q <= 1'b0;
            end else begin
              // last_q marks that the end point has been issued (or clipped).
              write_q <= on_screen;
              if (on_screen) begin
                addr_q <= pix_addr;
                data_q <= color;
              end
              if (at_end) begin
                last_q <= 1'b1;
              end else begin
                x   <= x_nxt;
                y   <= y_nxt;
                err <= err_nxt;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign avm.avm_address    = addr_q;
  assign avm.avm_write      = write_q;
  assign avm.avm_writedata  = data_q;
  assign avm.avm_byteenable = write_q ? BE_ALL : 2'b00;

endmodule
